uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte presented with the receiver's one-cycle done strobe and holds it in a circular FIFO. Bytes are presented to the consumer (command parser / bus bridge) over a first-word-fall-through valid/ready interface. It reports occupancy and flags and counts bytes lost to overflow.

---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 71 +++++++
 tb/tb_uart_rx_fifo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver / consumer side and the receive FIFO.
// Consumer handshake: a byte transfers on any rising edge where rd_valid=1 and rd_ready=1;
// rd_data is stable while rd_valid=1 and rd_ready=0, and rd_ready is ignored while rd_valid=0.
interface uart_rx_fifo_if #(
  parameter int width  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
);
  logic [width-1:0]  uart_rx_out;
  logic              uart_rx_done;
  logic [width-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;
  logic [7:0]        drop_count;
  logic              overflow_clr;

  modport slave (
    input  uart_rx_out, uart_rx_done, rd_ready, overflow_clr,
    output rd_data, rd_valid, fifo_count, fifo_full, fifo_empty, overflow, drop_count
  );

  modport master (
    output uart_rx_out, uart_rx_done, rd_ready, overflow_clr,
    input  rd_data, rd_valid, fifo_count, fifo_full, fifo_empty, overflow, drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular first-word-fall-through byte buffer behind the UART receiver,
// with a sticky overflow flag and a saturating count of dropped bytes.
module uart_rx_fifo #(
  parameter int width  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  uart_rx_fifo_if.slave   bus
);

  logic [width-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             r_overflow;
  logic [7:0]       r_drop_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_pop  = !w_empty && bus.rd_ready;
  assign w_push = bus.uart_rx_done && (!w_full || w_pop);
  assign w_drop = bus.uart_rx_done && w_full && !w_pop;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: it is only visible through rd_data when non-empty.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.uart_rx_out;
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.overflow_clr)           r_drop_count <= 8'd1;
      else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end else if (bus.overflow_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign bus.rd_data    = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign bus.rd_valid   = !w_empty;
  assign bus.fifo_count = r_wr_ptr - r_rd_ptr;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_empty = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_reset;
  always #5 sys_clk = ~sys_clk;

  uart_rx_fifo_if #(.width(W), .DEPTH(DEPTH), .ADDR_W(AW)) bus ();

  uart_rx_fifo #(.width(W), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  // reference model
  logic [W-1:0] exp_q[$];
  bit           m_ovf;
  int           m_drops;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_outputs(input string ctx);
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({ctx, ".rd_valid"},   32'(bus.rd_valid),   32'(exp_q.size() > 0));
    check({ctx, ".rd_data"},    32'(bus.rd_data),    32'(head));
    check({ctx, ".fifo_count"}, 32'(bus.fifo_count), 32'(exp_q.size()));
    check({ctx, ".fifo_full"},  32'(bus.fifo_full),  32'(exp_q.size() == DEPTH));
    check({ctx, ".fifo_empty"}, 32'(bus.fifo_empty), 32'(exp_q.size() == 0));
    check({ctx, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
    check({ctx, ".drop_count"}, 32'(bus.drop_count), 32'(m_drops));
  endtask

  // driver: one clock cycle with the given inputs, then model update and compare
  task automatic cycle(input string ctx, input logic done, input logic [W-1:0] data,
                       input logic ready, input logic clr);
    bit pop, push, drop;
    bus.uart_rx_done  = done;
    bus.uart_rx_out   = data;
    bus.rd_ready      = ready;
    bus.overflow_clr  = clr;
    pop  = (exp_q.size() > 0) && ready;
    push = done && ((exp_q.size() < DEPTH) || pop);
    drop = done && (exp_q.size() == DEPTH) && !pop;
    @(posedge sys_clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(data);
    if (drop) begin
      m_ovf   = 1'b1;
      m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle_inputs();
    bus.uart_rx_done = 1'b0;
    bus.uart_rx_out  = '0;
    bus.rd_ready     = 1'b0;
    bus.overflow_clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    sys_reset = 1'b1;
    #12 sys_reset = 1'b0;
    @(posedge sys_clk); #1;
    check_outputs("reset");

    // single byte
    cycle("single_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_data", 32'(bus.rd_data), 32'hA5);
    cycle("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // fill, partial drain, wrap
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(bus.fifo_full), 32'd1);
    for (int i = 0; i < 4; i++) cycle("pop4", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 16; i < 20; i++) cycle("wrap_push", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 4; i < 20; i++) begin
      check("drain_order", 32'(bus.rd_data), 32'(i));
      cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // overflow and clear
    for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("drop3", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("drop3_count", 32'(bus.drop_count), 32'd3);
    check("drop3_head", 32'(bus.rd_data), 32'h80);
    cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("clr_with_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
    check("clr_with_drop_cnt", 32'(bus.drop_count), 32'd1);
    cycle("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // full with simultaneous push and pop
    cycle("full_pushpop", 1'b1, 8'h5A, 1'b1, 1'b0);
    check("full_pushpop_ovf", 32'(bus.overflow), 32'd0);

    // drop counter saturation
    for (int i = 0; i < 260; i++) cycle("sat", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("sat_count", 32'(bus.drop_count), 32'd255);
    cycle("sat_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // asynchronous reset between edges
    idle_inputs();
    #3 sys_reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    #2 sys_reset = 1'b0;

    // reset during a push/pop cycle with data stored
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    bus.uart_rx_done = 1'b1;
    bus.uart_rx_out  = 8'h77;
    bus.rd_ready     = 1'b1;
    #2 sys_reset = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_reset");
    @(posedge sys_clk); #1;
    check_outputs("mid_reset_edge");
    idle_inputs();
    #2 sys_reset = 1'b0;
    cycle("post_rst_push", 1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_rst_data", 32'(bus.rd_data), 32'h3C);

    // random traffic: a fill-biased phase then a drain-biased phase
    for (int i = 0; i < 1500; i++) begin
      cycle("rand_fill", ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 3));
    end
    for (int i = 0; i < 1500; i++) begin
      cycle("rand_drain", ($urandom_range(0, 99) < 40), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 3));
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
